data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_if.sv | 55 +++++
 rtl/data_cache.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/data_cache_if.sv
// Load/store-unit and memory-side bus of the data cache, grouped so the
// cache and its environment connect through a single port each.
interface data_cache_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  // Load/store unit side
  logic                 dcache_prefetch;
  logic [AddrWidth-1:0] dcache_pre_addr;
  logic                 dcache_read;
  logic [AddrWidth-1:0] dcache_read_addr;
  logic                 dcache_read_done;
  logic [DataWidth-1:0] dcache_read_data;
  logic                 dcache_write;
  logic [AddrWidth-1:0] dcache_write_addr;
  logic [DataWidth-1:0] dcache_write_data;
  logic [3:0]           dcache_write_mask;
  logic                 dcache_write_done;

  // Memory side
  logic                 mem_read_req;
  logic [AddrWidth-1:0] mem_addr;
  logic                 mem_read_valid;
  logic [DataWidth-1:0] mem_read_data;
  logic                 mem_write_req;
  logic [DataWidth-1:0] mem_write_data;
  logic [3:0]           mem_write_mask;
  logic                 mem_write_ack;

  // Cache view
  modport slave (
    input  dcache_prefetch, dcache_pre_addr,
    input  dcache_read, dcache_read_addr,
    output dcache_read_done, dcache_read_data,
    input  dcache_write, dcache_write_addr, dcache_write_data, dcache_write_mask,
    output dcache_write_done,
    output mem_read_req, mem_addr,
    input  mem_read_valid, mem_read_data,
    output mem_write_req, mem_write_data, mem_write_mask,
    input  mem_write_ack
  );

  // Environment view: requester plus memory
  modport master (
    output dcache_prefetch, dcache_pre_addr,
    output dcache_read, dcache_read_addr,
    input  dcache_read_done, dcache_read_data,
    output dcache_write, dcache_write_addr, dcache_write_data, dcache_write_mask,
    input  dcache_write_done,
    input  mem_read_req, mem_addr,
    output mem_read_valid, mem_read_data,
    input  mem_write_req, mem_write_data, mem_write_mask,
    output mem_write_ack
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache with zero-latency read hits and a single-entry prefetch buffer.
module data_cache #(
  parameter int unsigned LINES = 16
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned IdxW      = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned TagW      = AddrWidth - IdxW - 2;

  typedef enum logic [1:0] {StIdle, StRdMiss, StPfFill, StWrThru} state_e;

  state_e               r_state;
  logic [LINES-1:0]     r_valid;
  logic [TagW-1:0]      r_tag  [LINES];
  logic [31:0]          r_data [LINES];
  logic                 r_pf_valid;
  logic [AddrWidth-1:0] r_pf_addr;
  logic                 r_mem_read_req;
  logic                 r_mem_write_req;
  logic [AddrWidth-1:0] r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic [3:0]           r_mem_wmask;

  logic [IdxW-1:0] w_rd_idx, w_pre_idx, w_pf_idx, w_mem_idx;
  logic            w_rd_hit, w_pre_hit, w_pf_hit, w_mem_hit;
  logic            w_pre_same, w_pf_latch;
  logic            w_idle_hit, w_rd_fill, w_pf_fill, w_wr_ack;

  assign w_rd_idx  = bus.dcache_read_addr[IdxW+1:2];
  assign w_pre_idx = bus.dcache_pre_addr[IdxW+1:2];
  assign w_pf_idx  = r_pf_addr[IdxW+1:2];
  assign w_mem_idx = r_mem_addr[IdxW+1:2];

  assign w_rd_hit  = r_valid[w_rd_idx] &&
                     (r_tag[w_rd_idx] == bus.dcache_read_addr[AddrWidth-1:IdxW+2]);
  assign w_pre_hit = r_valid[w_pre_idx] &&
                     (r_tag[w_pre_idx] == bus.dcache_pre_addr[AddrWidth-1:IdxW+2]);
  assign w_pf_hit  = r_valid[w_pf_idx] && (r_tag[w_pf_idx] == r_pf_addr[AddrWidth-1:IdxW+2]);
  assign w_mem_hit = r_valid[w_mem_idx] && (r_tag[w_mem_idx] == r_mem_addr[AddrWidth-1:IdxW+2]);

  // A level-held hint for an address already latched must not re-arm the buffer.
  assign w_pre_same = r_pf_valid &&
                      (bus.dcache_pre_addr[AddrWidth-1:2] == r_pf_addr[AddrWidth-1:2]);
  assign w_pf_latch = bus.dcache_prefetch && !w_pre_hit && !w_pre_same;

  assign w_idle_hit = !rst && (r_state == StIdle) && !bus.dcache_write &&
                      bus.dcache_read && w_rd_hit;
  assign w_rd_fill  = !rst && (r_state == StRdMiss) && bus.mem_read_valid;
  assign w_pf_fill  = !rst && (r_state == StPfFill) && bus.mem_read_valid;
  assign w_wr_ack   = !rst && (r_state == StWrThru) && bus.mem_write_ack;

  // Handshake outputs are forced low while reset is asserted.
  assign bus.dcache_read_done  = w_idle_hit || w_rd_fill;
  assign bus.dcache_read_data  = w_rd_fill ? bus.mem_read_data : r_data[w_rd_idx];
  assign bus.dcache_write_done = w_wr_ack;
  assign bus.mem_read_req      = r_mem_read_req && !rst;
  assign bus.mem_write_req     = r_mem_write_req && !rst;
  assign bus.mem_addr          = r_mem_addr;
  assign bus.mem_write_data    = r_mem_wdata;
  assign bus.mem_write_mask    = r_mem_wmask;

  // Controller: state, valid bits, prefetch buffer and registered memory requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= StIdle;
      r_valid         <= '0;
      r_pf_valid      <= 1'b0;
      r_pf_addr       <= '0;
      r_mem_read_req  <= 1'b0;
      r_mem_write_req <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
    end else begin
      if (w_pf_latch) begin
        r_pf_valid <= 1'b1;
        r_pf_addr  <= bus.dcache_pre_addr;
      end
      unique case (r_state)
        StIdle: begin
          if (bus.dcache_write) begin
            r_state         <= StWrThru;
            r_mem_write_req <= 1'b1;
            r_mem_addr      <= {bus.dcache_write_addr[AddrWidth-1:2], 2'b00};
            r_mem_wdata     <= bus.dcache_write_data;
            r_mem_wmask     <= bus.dcache_write_mask;
          end else if (bus.dcache_read) begin
            if (!w_rd_hit) begin
              r_state        <= StRdMiss;
              r_mem_read_req <= 1'b1;
              r_mem_addr     <= {bus.dcache_read_addr[AddrWidth-1:2], 2'b00};
            end
          end else if (r_pf_valid) begin
            if (w_pf_hit) begin
              if (!w_pf_latch) r_pf_valid <= 1'b0;
            end else begin
              r_state        <= StPfFill;
              r_mem_read_req <= 1'b1;
              r_mem_addr     <= {r_pf_addr[AddrWidth-1:2], 2'b00};
            end
          end
        end
        StRdMiss: begin
          if (bus.mem_read_valid) begin
            r_state            <= StIdle;
            r_mem_read_req     <= 1'b0;
            r_valid[w_mem_idx] <= 1'b1;
          end
        end
        StPfFill: begin
          if (bus.mem_read_valid) begin
            r_state            <= StIdle;
            r_mem_read_req     <= 1'b0;
            r_valid[w_mem_idx] <= 1'b1;
            // Keep a newer hint that replaced the one being filled.
            if (!w_pf_latch && (r_pf_addr[AddrWidth-1:2] == r_mem_addr[AddrWidth-1:2])) begin
              r_pf_valid <= 1'b0;
            end
          end
        end
        StWrThru: begin
          if (bus.mem_write_ack) begin
            r_state         <= StIdle;
            r_mem_write_req <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Tag/data array: fills from memory, byte-merge of write-through stores on a hit.
  always_ff @(posedge clk) begin
    if (w_rd_fill || w_pf_fill) begin
      r_tag[w_mem_idx]  <= r_mem_addr[AddrWidth-1:IdxW+2];
      r_data[w_mem_idx] <= bus.mem_read_data;
    end else if (w_wr_ack && w_mem_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mem_wmask[b]) r_data[w_mem_idx][8*b +: 8] <= r_mem_wdata[8*b +: 8];
      end
    end
  end

endmodule
